// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - constants and types shared by the fetch, decode and execute stages
package cpu_pkg;

  localparam logic [31:0] NOP_INSN = 32'd0;

  localparam logic [4:0] OPC_J   = 5'b00001;
  localparam logic [4:0] OPC_JAL = 5'b00011;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HELD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/adder32.sv
// rtl/adder32.sv - 32-bit modulo adder, no carry out
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {insn, pc} holding register
// Priority: reset/flush, then load, then drain.
module fetch_skid_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_insn,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] insn,
  output logic [31:0] pc
);

  logic        r_valid;
  logic [31:0] r_insn;
  logic [31:0] r_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_insn  <= 32'd0;
      r_pc    <= 32'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_insn  <= load_insn;
      r_pc    <= load_pc;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign insn  = r_insn;
  assign pc    = r_pc;

endmodule

// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage: PC, ROM request tracking, skid buffer, F/D outputs
// The fetch state is derived from the request/skid valid bits rather than stored separately.
module stage_fetch
  import cpu_pkg::*;
#(
  parameter int          IMEM_ADDR_W = 12,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branched_jumped,
  input  logic [31:0]            pc_in,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_q,
  output logic [31:0]            insn_fd,
  output logic [31:0]            pc_fd,
  output logic                   valid_fd,
  output logic [4:0]             pc_upper_5
);

  logic [31:0] r_pc_q;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic [31:0] r_insn_fd;
  logic [31:0] r_pc_fd;
  logic        r_valid_fd;

  fetch_state_t w_state;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_fd_src_pc;
  logic [31:0]  w_fd_pc_inc;
  logic         w_skid_valid;
  logic [31:0]  w_skid_insn;
  logic [31:0]  w_skid_pc;
  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_flush;
  logic [31:0]  w_pc_nxt;
  logic         w_req_valid_nxt;
  logic [31:0]  w_req_pc_nxt;
  logic [31:0]  w_insn_nxt;
  logic [31:0]  w_pc_fd_nxt;
  logic         w_valid_nxt;

  adder32 u_pc_inc (
    .a   (r_pc_q),
    .b   (32'd1),
    .sum (w_pc_inc)
  );

  assign w_fd_src_pc = w_skid_valid ? w_skid_pc : r_req_pc;

  adder32 u_fd_pc_inc (
    .a   (w_fd_src_pc),
    .b   (32'd1),
    .sum (w_fd_pc_inc)
  );

  fetch_skid_buffer u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_skid_flush),
    .load      (w_skid_load),
    .drain     (w_skid_drain),
    .load_insn (imem_q),
    .load_pc   (r_req_pc),
    .valid     (w_skid_valid),
    .insn      (w_skid_insn),
    .pc        (w_skid_pc)
  );

  always_comb begin
    w_state = FILL;
    if (w_skid_valid) begin
      w_state = HELD;
    end else if (r_req_valid) begin
      w_state = RUN;
    end
  end

  always_comb begin
    w_pc_nxt        = r_pc_q;
    w_req_valid_nxt = r_req_valid;
    w_req_pc_nxt    = r_req_pc;
    w_insn_nxt      = r_insn_fd;
    w_pc_fd_nxt     = r_pc_fd;
    w_valid_nxt     = r_valid_fd;
    w_skid_load     = 1'b0;
    w_skid_drain    = 1'b0;
    w_skid_flush    = 1'b0;

    if (branched_jumped) begin
      w_pc_nxt        = pc_in;
      w_req_valid_nxt = 1'b0;
      w_insn_nxt      = NOP_INSN;
      w_pc_fd_nxt     = 32'd0;
      w_valid_nxt     = 1'b0;
      w_skid_flush    = 1'b1;
    end else if (stall) begin
      // Park the in-flight ROM word so the stall cannot drop it.
      if (w_state == RUN) begin
        w_skid_load     = 1'b1;
        w_req_valid_nxt = 1'b0;
      end
    end else begin
      case (w_state)
        HELD: begin
          w_insn_nxt   = w_skid_insn;
          w_pc_fd_nxt  = w_fd_pc_inc;
          w_valid_nxt  = 1'b1;
          w_skid_drain = 1'b1;
        end
        RUN: begin
          w_insn_nxt  = imem_q;
          w_pc_fd_nxt = w_fd_pc_inc;
          w_valid_nxt = 1'b1;
        end
        default: begin
          w_insn_nxt  = NOP_INSN;
          w_pc_fd_nxt = 32'd0;
          w_valid_nxt = 1'b0;
        end
      endcase
      w_req_valid_nxt = 1'b1;
      w_req_pc_nxt    = r_pc_q;
      w_pc_nxt        = w_pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc_q      <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= 32'd0;
      r_insn_fd   <= NOP_INSN;
      r_pc_fd     <= 32'd0;
      r_valid_fd  <= 1'b0;
    end else begin
      r_pc_q      <= w_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_insn_fd   <= w_insn_nxt;
      r_pc_fd     <= w_pc_fd_nxt;
      r_valid_fd  <= w_valid_nxt;
    end
  end

  a_req_skid_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(r_req_valid && w_skid_valid));

  assign imem_addr  = r_pc_q[IMEM_ADDR_W-1:0];
  assign insn_fd    = r_insn_fd;
  assign pc_fd      = r_pc_fd;
  assign valid_fd   = r_valid_fd;
  assign pc_upper_5 = r_pc_fd[31:27];

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Instruction-fetch stage. It is the producer end of the PC and redirect interface that the execute stage consumes.
- Owns the PC register and drives the synchronous instruction ROM.
- Presents insn_fd and pc_fd (PC+1) to the F/D latch consumers, which are the decoder and the execute-stage branch adder.
- Accepts branch/jump redirects (pc_in, branched_jumped) and a hazard stall. A one-entry skid buffer absorbs the ROM's 1-cycle read latency, so a stall never loses an instruction.

Parameters:
- IMEM_ADDR_W, 12: ROM word-address width; imem_addr = pc_q[IMEM_ADDR_W-1:0].
- RESET_PC, 32'd0: PC loaded on reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard-unit stall; freezes PC and F/D outputs.
- branched_jumped  in  1  execute-stage redirect request.
- pc_in  in  32  redirect target; sampled only when branched_jumped=1.
- imem_addr  out  IMEM_ADDR_W  ROM address, combinational from pc_q.
- imem_q  in  32  ROM data for the address presented in the previous cycle.
- insn_fd  out  32  fetched instruction; 32'd0 (nop) when invalid.
- pc_fd  out  32  address of insn_fd plus 1.
- valid_fd  out  1  insn_fd/pc_fd hold a real instruction.
- pc_upper_5  out  5  pc_fd[31:27], for j/jal/setx target formation.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values: pc_q=RESET_PC; insn_fd=0, pc_fd=0, valid_fd=0; req_valid=0; skid_valid=0; state=FILL.
- Reset mid-operation: reset wins over stall and redirect; in-flight and skid contents are discarded.
- Internal registers:
  - req_valid/req_pc: a ROM read issued last edge; its data is on imem_q now.
  - skid_valid/skid_insn/skid_pc: one-entry skid buffer.
- FSM, derived from the register state:
  - FILL: req_valid=0, skid_valid=0.
  - RUN: req_valid=1.
  - HELD: skid_valid=1.
  - req_valid and skid_valid are never both 1; assert this.
- Priority per edge: reset > branched_jumped > stall > advance.
- Redirect (branched_jumped=1, regardless of stall):
  - pc_q<=pc_in; valid_fd<=0, insn_fd<=0, pc_fd<=0.
  - req_valid<=0, skid_valid<=0; state->FILL.
- Stall (no redirect):
  - pc_q, insn_fd, pc_fd, valid_fd hold.
  - In RUN: skid<={imem_q, req_pc}, skid_valid<=1, req_valid<=0; state->HELD.
  - In FILL or HELD: no change. Repeated ROM reads of pc_q during stall are ignored.
- Advance (no redirect, stall=0):
  - HELD: fd<={skid_insn, skid_pc+1, valid=1}; skid_valid<=0.
  - RUN: fd<={imem_q, req_pc+1, valid=1}.
  - FILL: fd<={0, 0, valid=0}.
  - Always: req_valid<=1, req_pc<=pc_q, pc_q<=pc_q+1; state->RUN.
- Latency:
  - After reset release, or after the redirect edge, the first valid F/D instruction appears after the 2nd following edge.
  - Redirect costs 2 bubbles plus the flushed F/D slot.
  - Stall release costs 0 bubbles (skid drains while the next read issues).
- Arithmetic: pc_q+1 and pc_fd are 32-bit modulo; 32'hFFFFFFFF wraps to 0. imem_addr truncates the upper bits.
- pc_in is ignored when branched_jumped=0, including the case pc_in=0.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSN=32'd0.
  - Fetch state encodings FILL=2'd0, RUN=2'd1, HELD=2'd2.
  - Opcode constants for j/jal (5'b00001, 5'b00011), shared with decode/execute.
- One natural sub-module: fetch_skid_buffer (one-entry {insn, pc} register with load/drain/flush).
- The PC incrementer reuses the existing adder32.

Test Plan:
- Reset then run, ROM[i]=0x1000+i:
  - After the 2nd edge post-reset, insn_fd=0x1000, pc_fd=1, valid_fd=1.
  - Each subsequent edge: insn_fd=0x1000+k, pc_fd=k+1.
- Stall for 3 cycles while insn_fd=0x1003:
  - Outputs hold 0x1003/pc_fd=4 throughout.
  - On release the next edges give 0x1004 then 0x1005, with no gap and no duplicate.
- branched_jumped=1, pc_in=0x40 while streaming:
  - Next edge valid_fd=0, insn_fd=0.
  - 2 edges later insn_fd=ROM[0x40], pc_fd=0x41.
- Redirect and stall asserted together in HELD:
  - Skid is flushed; the stalled instruction never appears.
  - First valid output is ROM[pc_in].
- Reset asserted during a stall with the skid full:
  - Next edge all outputs are 0 and pc_q=RESET_PC.
  - Stream restarts from ROM[0].
- Redirect to pc_in=0xFFFFFFFF:
  - Outputs pc_fd=0 (wrap) for that instruction.
  - Next fetch uses imem_addr=0.
